// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared constants, baud table and FSM encoding for the 6-byte UART.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int unsigned NUM_BYTES = 6;
    localparam int unsigned DATA_W    = 46;
    localparam int unsigned FRAME_W   = 48;
    localparam int unsigned DIV_W     = 16;
    localparam int          NUM_RATES = 8;

    localparam int unsigned BAUD_RATE [NUM_RATES] = '{
        9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600
    };

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_DONE  = 3'd4
    } tx_state_e;

    // Truncating divide; the receiver derives its bit period the same way.
    function automatic logic [DIV_W-1:0] baud_div(input int unsigned clk_hz,
                                                  input logic [2:0]  sel);
        return DIV_W'(clk_hz / BAUD_RATE[sel]);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_byte_tx.sv
// ============================================================================
// Module   : uart_byte_tx
// Purpose  : Single-byte 8N1 serialiser; a start may be taken in the last
//            stop-bit cycle so consecutive bytes abut with no idle gap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_byte_tx
    import uart_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic [7:0]       byte_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tx_o,
    output logic             bit_tick_o,
    output logic             byte_done_o
);

    logic [DIV_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]       bit_cnt_q,  bit_cnt_d;
    logic [8:0]       shreg_q,    shreg_d;
    logic             busy_q,     busy_d;
    logic             tx_q,       tx_d;
    logic             w_tick;
    logic             w_last;

    assign w_tick      = busy_q && (baud_cnt_q == (div_i - DIV_W'(1)));
    assign w_last      = w_tick && (bit_cnt_q == 4'd9);
    assign tx_o        = tx_q;
    assign bit_tick_o  = w_tick;
    assign byte_done_o = w_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            busy_q     <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            busy_q     <= busy_d;
            tx_q       <= tx_d;
        end
    end

    // shreg holds d0..d7 followed by the stop bit, shifted out LSB first.
    always_comb begin
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        busy_d     = busy_q;
        tx_d       = tx_q;
        if (start_i && (!busy_q || w_last)) begin
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
            shreg_d    = {1'b1, byte_i};
            busy_d     = 1'b1;
            tx_d       = 1'b0;
        end else if (busy_q) begin
            if (w_tick) begin
                baud_cnt_d = '0;
                if (w_last) begin
                    busy_d = 1'b0;
                    tx_d   = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    tx_d      = shreg_q[0];
                    shreg_d   = {1'b1, shreg_q[8:1]};
                end
            end else begin
                baud_cnt_d = baud_cnt_q + DIV_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_6byte_tx.sv
// ============================================================================
// Module   : uart_6byte_tx
// Purpose  : Sends a 46-bit word as six back-to-back 8N1 bytes, MSB byte first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_6byte_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000
)
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        baud_set,
    input  logic [DATA_W-1:0] data_46bit,
    input  logic              send_en,
    output logic              uart_tx,
    output logic              tx_busy,
    output logic              tx_6byte_done
);

    localparam logic [2:0] LAST_BYTE = 3'(NUM_BYTES - 1);

    tx_state_e          state_q,    state_d;
    logic [FRAME_W-1:0] buf_q,      buf_d;
    logic [2:0]         baud_q,     baud_d;
    logic [2:0]         byte_idx_q, byte_idx_d;
    logic [2:0]         bit_cnt_q,  bit_cnt_d;

    logic [DIV_W-1:0]   w_div_tab [NUM_RATES];
    logic [DIV_W-1:0]   w_div;
    logic [FRAME_W-1:0] w_frame_in;
    logic               w_accept;
    logic               w_next_byte;
    logic               w_sub_start;
    logic [7:0]         w_sub_byte;
    logic               w_sub_tx;
    logic               w_bit_tick;
    logic               w_byte_done;

    for (genvar gi = 0; gi < NUM_RATES; gi++) begin : g_div_tab
        assign w_div_tab[gi] = baud_div(CLK_FREQ_HZ, 3'(gi));
    end

    assign w_div       = w_div_tab[baud_q];
    assign w_frame_in  = {{(FRAME_W-DATA_W){1'b0}}, data_46bit};
    assign w_accept    = send_en && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign w_next_byte = (state_q == ST_STOP) && w_byte_done && (byte_idx_q != LAST_BYTE);

    uart_byte_tx u_byte_tx (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_i     (w_sub_start),
        .byte_i      (w_sub_byte),
        .div_i       (w_div),
        .tx_o        (w_sub_tx),
        .bit_tick_o  (w_bit_tick),
        .byte_done_o (w_byte_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            buf_q      <= '0;
            baud_q     <= '0;
            byte_idx_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            baud_q     <= baud_d;
            byte_idx_q <= byte_idx_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    // buf_q holds the bytes still to be sent, next one in [47:40].
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        baud_d     = baud_q;
        byte_idx_d = byte_idx_q;
        bit_cnt_d  = bit_cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (send_en) begin
                    state_d    = ST_START;
                    buf_d      = {w_frame_in[FRAME_W-9:0], 8'h00};
                    baud_d     = baud_set;
                    byte_idx_d = '0;
                    bit_cnt_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (w_bit_tick) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (w_bit_tick) begin
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (w_byte_done) begin
                    if (byte_idx_q == LAST_BYTE) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d    = ST_START;
                        byte_idx_d = byte_idx_q + 3'd1;
                        buf_d      = {buf_q[FRAME_W-9:0], 8'h00};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        w_sub_start   = w_accept || w_next_byte;
        w_sub_byte    = w_accept ? w_frame_in[FRAME_W-1:FRAME_W-8] : buf_q[FRAME_W-1:FRAME_W-8];
        uart_tx       = w_sub_tx;
        tx_busy       = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);
        tx_6byte_done = (state_q == ST_DONE);
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_6byte_tx.sv
// ============================================================================
// Module   : tb_uart_6byte_tx
// Purpose  : Directed self-checking bench for uart_6byte_tx at a 2 MHz clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_6byte_tx;

    // 2 MHz keeps frames short; divisors are 208,104,52,34,17,8,4,2.
    localparam int unsigned CLK_HZ = 2_000_000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        send_en;
    logic [2:0]  baud_set;
    logic [45:0] data_46bit;
    logic        uart_tx;
    logic        tx_busy;
    logic        tx_6byte_done;

    int checks = 0;
    int errors = 0;

    logic q_tx[$];
    logic q_busy[$];
    logic q_done[$];

    uart_6byte_tx #(.CLK_FREQ_HZ(CLK_HZ)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .baud_set      (baud_set),
        .data_46bit    (data_46bit),
        .send_en       (send_en),
        .uart_tx       (uart_tx),
        .tx_busy       (tx_busy),
        .tx_6byte_done (tx_6byte_done)
    );

    always #5 clk = ~clk;

    task automatic launch(input logic [45:0] d, input logic [2:0] b);
        @(negedge clk);
        data_46bit = d;
        baud_set   = b;
        send_en    = 1'b1;
        @(posedge clk);
    endtask

    // Index 0 is the first cycle after the accepting edge.
    task automatic capture(input int n, input int drop_at, input int pulse_at,
                           input int swap_at, input logic [45:0] alt_data);
        q_tx.delete();
        q_busy.delete();
        q_done.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            q_tx.push_back(uart_tx);
            q_busy.push_back(tx_busy);
            q_done.push_back(tx_6byte_done);
            if (i == drop_at) send_en = 1'b0;
            if (i == swap_at) data_46bit = alt_data;
            if (i == pulse_at) begin
                data_46bit = alt_data;
                send_en    = 1'b1;
            end else if (i == pulse_at + 1) begin
                send_en = 1'b0;
            end
        end
    endtask

    function automatic logic [47:0] decode(input int base, input int div);
        logic [47:0] w;
        w = '0;
        for (int b = 0; b < 6; b++)
            for (int k = 0; k < 8; k++)
                w[40 - 8*b + k] = q_tx[base + (b*10 + 1 + k)*div + div/2];
        return w;
    endfunction

    function automatic int frame_errs(input int base, input int div);
        int e;
        e = 0;
        for (int b = 0; b < 6; b++) begin
            if (q_tx[base + (b*10)*div + div/2] !== 1'b0) e++;
            if (q_tx[base + (b*10 + 9)*div + div/2] !== 1'b1) e++;
        end
        return e;
    endfunction

    function automatic int count_done();
        int c;
        c = 0;
        foreach (q_done[i]) if (q_done[i] === 1'b1) c++;
        return c;
    endfunction

    task automatic test_reset();
        reset_n    = 1'b0;
        send_en    = 1'b0;
        data_46bit = '0;
        baud_set   = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", uart_tx); end
        checks++;
        if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", tx_busy); end
        checks++;
        if (tx_6byte_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", tx_6byte_done); end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (uart_tx !== 1'b1 || tx_busy !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: tx=%b busy=%b expected tx=1 busy=0", uart_tx, tx_busy);
        end
    endtask

    task automatic test_basic();
        logic [47:0] got;
        int bad;
        launch(46'h3ABCDEF01234, 3'd4);
        capture(60*17 + 6, 0, -1, -1, '0);
        checks++;
        if (q_tx[0] !== 1'b0 || q_busy[0] !== 1'b1) begin
            errors++; $display("FAIL basic_first_cycle: tx=%b busy=%b expected tx=0 busy=1", q_tx[0], q_busy[0]);
        end
        got = decode(0, 17);
        checks++;
        if (got !== 48'h3ABCDEF01234) begin errors++; $display("FAIL basic_data: got %h expected 3abcdef01234", got); end
        checks++;
        if (frame_errs(0, 17) != 0) begin errors++; $display("FAIL basic_framing: got %0d bad start/stop expected 0", frame_errs(0, 17)); end
        checks++;
        if (q_done[1020] !== 1'b1 || count_done() != 1) begin
            errors++; $display("FAIL basic_done: done@1020=%b pulses=%0d expected 1 and 1", q_done[1020], count_done());
        end
        bad = 0;
        for (int i = 0; i < 1020; i++) if (q_busy[i] !== 1'b1) bad++;
        if (q_busy[1020] !== 1'b0) bad++;
        for (int i = 1020; i < q_tx.size(); i++) if (q_tx[i] !== 1'b1) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL basic_busy_line: got %0d bad samples expected 0", bad); end
    endtask

    task automatic test_zero_slow();
        logic [47:0] got;
        int bad;
        launch(46'h0, 3'd0);
        capture(60*208 + 3, 0, -1, -1, '0);
        got = decode(0, 208);
        checks++;
        if (got !== 48'h0) begin errors++; $display("FAIL zero_data: got %h expected 000000000000", got); end
        bad = 0;
        for (int i = 0; i < 60*208; i++)
            if (q_tx[i] !== (((i / 208) % 10) == 9)) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL zero_bit_times: got %0d bad samples expected 0", bad); end
        checks++;
        if (q_done[12480] !== 1'b1 || count_done() != 1) begin
            errors++; $display("FAIL zero_done: done@12480=%b pulses=%0d expected 1 and 1", q_done[12480], count_done());
        end
    endtask

    task automatic test_alt_fast();
        logic [47:0] got;
        launch(46'h2AAAAAAAAAAA, 3'd7);
        capture(124, 0, -1, -1, '0);
        got = decode(0, 2);
        checks++;
        if (got !== 48'h2AAAAAAAAAAA) begin errors++; $display("FAIL alt_data: got %h expected 2aaaaaaaaaaa", got); end
        checks++;
        if (q_done[120] !== 1'b1 || count_done() != 1) begin
            errors++; $display("FAIL alt_done: done@120=%b pulses=%0d expected 1 and 1", q_done[120], count_done());
        end
    endtask

    task automatic test_busy_reject();
        logic [47:0] got;
        int bad;
        launch(46'h123456789ABC, 3'd5);
        capture(600, 0, 100, -1, 46'h1);
        got = decode(0, 8);
        checks++;
        if (got !== 48'h123456789ABC) begin errors++; $display("FAIL reject_data: got %h expected 123456789abc", got); end
        checks++;
        if (q_done[480] !== 1'b1 || count_done() != 1) begin
            errors++; $display("FAIL reject_done: done@480=%b pulses=%0d expected 1 and 1", q_done[480], count_done());
        end
        bad = 0;
        for (int i = 481; i < 600; i++) if (q_tx[i] !== 1'b1 || q_busy[i] !== 1'b0) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL reject_no_retx: got %0d busy/low samples expected 0", bad); end
    endtask

    task automatic test_back_to_back();
        logic [47:0] got;
        launch(46'h111, 3'd6);
        capture(490, 241, -5, 0, 46'h222);
        got = decode(0, 4);
        checks++;
        if (got !== 48'h111) begin errors++; $display("FAIL b2b_first: got %h expected 000000000111", got); end
        checks++;
        if (q_done[240] !== 1'b1) begin errors++; $display("FAIL b2b_done1: got %b expected 1", q_done[240]); end
        checks++;
        if (q_tx[241] !== 1'b0 || q_busy[241] !== 1'b1) begin
            errors++; $display("FAIL b2b_no_gap: tx=%b busy=%b expected tx=0 busy=1", q_tx[241], q_busy[241]);
        end
        got = decode(241, 4);
        checks++;
        if (got !== 48'h222) begin errors++; $display("FAIL b2b_second: got %h expected 000000000222", got); end
        checks++;
        if (q_done[481] !== 1'b1 || count_done() != 2) begin
            errors++; $display("FAIL b2b_done2: done@481=%b pulses=%0d expected 1 and 2", q_done[481], count_done());
        end
    endtask

    task automatic test_async_reset();
        logic [47:0] got;
        int bad;
        launch(46'h0, 3'd4);
        capture(400, 0, -1, -1, '0);
        checks++;
        if (uart_tx !== 1'b0 || tx_busy !== 1'b1) begin
            errors++; $display("FAIL areset_pre: tx=%b busy=%b expected tx=0 busy=1", uart_tx, tx_busy);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (uart_tx !== 1'b1 || tx_busy !== 1'b0 || tx_6byte_done !== 1'b0) begin
            errors++; $display("FAIL areset_immediate: tx=%b busy=%b done=%b expected 1 0 0", uart_tx, tx_busy, tx_6byte_done);
        end
        @(negedge clk);
        reset_n = 1'b1;
        capture(100, 0, -1, -1, '0);
        bad = 0;
        foreach (q_tx[i]) if (q_tx[i] !== 1'b1 || q_done[i] !== 1'b0 || q_busy[i] !== 1'b0) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL areset_quiet: got %0d active samples expected 0", bad); end
        launch(46'h2BCDEF012345, 3'd4);
        capture(60*17 + 4, 0, -1, -1, '0);
        got = decode(0, 17);
        checks++;
        if (got !== 48'h2BCDEF012345) begin errors++; $display("FAIL areset_fresh_data: got %h expected 2bcdef012345", got); end
        checks++;
        if (q_done[1020] !== 1'b1 || count_done() != 1) begin
            errors++; $display("FAIL areset_fresh_done: done@1020=%b pulses=%0d expected 1 and 1", q_done[1020], count_done());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_slow();
        test_alt_fast();
        test_busy_reject();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
